// File: rtl/sa_ar_arbiter.sv
// sa_ar_arbiter: round-robin per-slave AR arbiter with a registered AR stage and an R-path owner FIFO
module sa_ar_arbiter #(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int MST_ID_W          = $clog2(MST_AMT)
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESETn_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_ARID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_ARADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_ARBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_ARLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_ARSIZE_i,
  input  logic [MST_AMT-1:0]                    dsp_ARVALID_i,
  input  logic [MST_AMT-1:0]                    dsp_AR_outst_full_i,
  output logic [MST_AMT-1:0]                    dsp_ARREADY_o,
  output logic [TRANS_MST_ID_W-1:0]             s_ARID_o,
  output logic [ADDR_WIDTH-1:0]                 s_ARADDR_o,
  output logic [TRANS_BURST_W-1:0]              s_ARBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_ARLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]          s_ARSIZE_o,
  output logic                                  s_ARVALID_o,
  input  logic                                  s_ARREADY_i,
  input  logic                                  s_RVALID_i,
  input  logic                                  s_RREADY_i,
  input  logic                                  s_RLAST_i,
  output logic [MST_ID_W-1:0]                   rd_mst_id_o,
  output logic                                  rd_mst_vld_o,
  output logic                                  ord_full_o
);
  localparam int OPW = $clog2(OUTSTANDING_AMT);
  localparam int CW  = OPW + 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t              state;
  logic [MST_AMT-1:0]  elig;
  logic [MST_ID_W-1:0] ptr, gnt, ptr_nxt;
  logic                accept, pop;
  int                  idx;
  logic [MST_ID_W-1:0] mem [OUTSTANDING_AMT];
  logic [OPW-1:0]      wr, rd;
  logic [CW-1:0]       cnt;
  // Scan downwards so the eligible index closest to ptr is the last one written.
  always_comb begin
    elig = dsp_ARVALID_i & ~dsp_AR_outst_full_i;
    gnt = '0;
    idx = 0;
    for (int k = MST_AMT - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % MST_AMT;
      if (elig[idx]) gnt = MST_ID_W'(idx);
    end
  end
  assign accept        = ARESETn_i && state == IDLE && |elig && !ord_full_o;
  assign dsp_ARREADY_o = accept ? MST_AMT'(1) << gnt : '0;
  assign ptr_nxt       = gnt == MST_ID_W'(MST_AMT - 1) ? '0 : gnt + MST_ID_W'(1);
  assign pop           = s_RVALID_i & s_RREADY_i & s_RLAST_i & rd_mst_vld_o;
  assign rd_mst_vld_o  = cnt != '0;
  assign ord_full_o    = cnt == CW'(OUTSTANDING_AMT);
  assign rd_mst_id_o   = mem[rd];
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      state       <= IDLE;
      ptr         <= '0;
      s_ARVALID_o <= 1'b0;
      s_ARID_o    <= '0;
      s_ARADDR_o  <= '0;
      s_ARBURST_o <= '0;
      s_ARLEN_o   <= '0;
      s_ARSIZE_o  <= '0;
      wr          <= '0;
      rd          <= '0;
      cnt         <= '0;
      for (int i = 0; i < OUTSTANDING_AMT; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        state       <= SEND;
        s_ARVALID_o <= 1'b1;
        ptr         <= ptr_nxt;
        s_ARID_o    <= dsp_ARID_i[gnt*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        s_ARADDR_o  <= dsp_ARADDR_i[gnt*ADDR_WIDTH +: ADDR_WIDTH];
        s_ARBURST_o <= dsp_ARBURST_i[gnt*TRANS_BURST_W +: TRANS_BURST_W];
        s_ARLEN_o   <= dsp_ARLEN_i[gnt*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
        s_ARSIZE_o  <= dsp_ARSIZE_i[gnt*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
        mem[wr]     <= gnt;
        wr          <= wr == OPW'(OUTSTANDING_AMT - 1) ? '0 : wr + OPW'(1);
      end else if (state == SEND && s_ARREADY_i) begin
        state       <= IDLE;
        s_ARVALID_o <= 1'b0;
      end
      if (pop) rd <= rd == OPW'(OUTSTANDING_AMT - 1) ? '0 : rd + OPW'(1);
      cnt <= cnt + CW'(accept) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_sa_ar_arbiter.sv
// tb_sa_ar_arbiter: directed literal checks plus randomized traffic against a queue-based reference model
module tb_sa_ar_arbiter;
  localparam int M = 2, OUT = 8, AW = 32, IW = 5, BW = 2, LW = 3, SW = 3, MW = 1;
  logic clk = 0, rstn = 0;
  logic [IW*M-1:0] arid = '0;
  logic [AW*M-1:0] araddr = '0;
  logic [BW*M-1:0] arburst = '0;
  logic [LW*M-1:0] arlen = '0;
  logic [SW*M-1:0] arsize = '0;
  logic [M-1:0] arvalid = '0, afull = '0, arready;
  logic [IW-1:0] s_id;
  logic [AW-1:0] s_addr;
  logic [BW-1:0] s_burst;
  logic [LW-1:0] s_len;
  logic [SW-1:0] s_size;
  logic s_valid, s_ready = 0, rv = 0, rr = 0, rl = 0;
  logic [MW-1:0] rd_id;
  logic rd_vld, ord_full;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sa_ar_arbiter #(.MST_AMT(M), .OUTSTANDING_AMT(OUT), .ADDR_WIDTH(AW), .TRANS_MST_ID_W(IW),
    .TRANS_BURST_W(BW), .TRANS_DATA_LEN_W(LW), .TRANS_DATA_SIZE_W(SW), .MST_ID_W(MW)) dut (
    .ACLK_i(clk), .ARESETn_i(rstn),
    .dsp_ARID_i(arid), .dsp_ARADDR_i(araddr), .dsp_ARBURST_i(arburst), .dsp_ARLEN_i(arlen),
    .dsp_ARSIZE_i(arsize), .dsp_ARVALID_i(arvalid), .dsp_AR_outst_full_i(afull),
    .dsp_ARREADY_o(arready), .s_ARID_o(s_id), .s_ARADDR_o(s_addr), .s_ARBURST_o(s_burst),
    .s_ARLEN_o(s_len), .s_ARSIZE_o(s_size), .s_ARVALID_o(s_valid), .s_ARREADY_i(s_ready),
    .s_RVALID_i(rv), .s_RREADY_i(rr), .s_RLAST_i(rl),
    .rd_mst_id_o(rd_id), .rd_mst_vld_o(rd_vld), .ord_full_o(ord_full));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending-AR flag, the captured payload, the rotation pointer and a queue of owners.
  bit mbusy = 0, started = 0;
  int mptr = 0;
  int mq[$];
  logic [IW-1:0] m_id;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_burst;
  logic [LW-1:0] m_len;
  logic [SW-1:0] m_size;

  function automatic int exp_accept();
    int g = -1;
    if (!rstn || mbusy || mq.size() >= OUT) return -1;
    for (int k = 0; k < M && g < 0; k++)
      if (arvalid[(mptr + k) % M] && !afull[(mptr + k) % M]) g = (mptr + k) % M;
    return g;
  endfunction

  always @(posedge clk) begin
    int g;
    bit p;
    g = exp_accept();
    if (!rstn) begin
      mbusy = 0; mptr = 0; mq.delete();
    end else begin
      p = rv && rr && rl && mq.size() > 0;
      if (mbusy && s_ready) mbusy = 0;
      else if (g >= 0) begin
        mbusy = 1;
        mptr = (g + 1) % M;
        m_id = arid[g*IW +: IW];
        m_addr = araddr[g*AW +: AW];
        m_burst = arburst[g*BW +: BW];
        m_len = arlen[g*LW +: LW];
        m_size = arsize[g*SW +: SW];
      end
      if (p) void'(mq.pop_front());
      if (g >= 0) mq.push_back(g);
    end
    started = 1;
  end

  always @(negedge clk) if (started) begin
    int g;
    g = exp_accept();
    chk("m_arready", 64'(arready), g >= 0 ? 64'(1 << g) : 64'd0);
    chk("m_arvalid", 64'(s_valid), 64'(mbusy));
    if (mbusy) begin
      chk("m_arid", 64'(s_id), 64'(m_id));
      chk("m_araddr", 64'(s_addr), 64'(m_addr));
      chk("m_arburst", 64'(s_burst), 64'(m_burst));
      chk("m_arlen", 64'(s_len), 64'(m_len));
      chk("m_arsize", 64'(s_size), 64'(m_size));
    end
    chk("m_rd_vld", 64'(rd_vld), 64'(mq.size() > 0));
    if (mq.size() > 0) chk("m_rd_id", 64'(rd_id), 64'(mq[0]));
    chk("m_ord_full", 64'(ord_full), 64'(mq.size() == OUT));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rlast(input logic v);
    rv = v; rr = v; rl = v;
  endtask

  initial begin
    int rl_pct;
    arvalid = 2'b11;
    repeat (3) step();
    @(negedge clk);
    chk("rst_arvalid", 64'(s_valid), 0);
    chk("rst_arready", 64'(arready), 0);
    chk("rst_rd_vld", 64'(rd_vld), 0);
    chk("rst_full", 64'(ord_full), 0);
    chk("rst_rd_id", 64'(rd_id), 0);
    chk("rst_addr", 64'(s_addr), 0);
    chk("rst_id", 64'(s_id), 0);
    step(); rstn = 1; arid = {5'd9, 5'd3}; s_ready = 1;
    @(negedge clk); chk("a_grant0", 64'(arready), 2'b01);
    step();
    @(negedge clk);
    chk("a_send0", 64'(s_valid), 1); chk("a_id0", 64'(s_id), 3);
    chk("a_nordy", 64'(arready), 0); chk("a_vld", 64'(rd_vld), 1); chk("a_own0", 64'(rd_id), 0);
    step();
    @(negedge clk); chk("a_grant1", 64'(arready), 2'b10); chk("a_idle", 64'(s_valid), 0);
    step(); arvalid = 2'b00;
    @(negedge clk); chk("a_send1", 64'(s_valid), 1); chk("a_id1", 64'(s_id), 9); chk("a_own0b", 64'(rd_id), 0);
    step(); rlast(1);
    @(negedge clk); chk("a_idle2", 64'(s_valid), 0);
    step(); rlast(0);
    @(negedge clk); chk("a_own1", 64'(rd_id), 1); chk("a_vld1", 64'(rd_vld), 1);
    step(); rlast(1);
    step(); rlast(0);
    @(negedge clk); chk("a_empty", 64'(rd_vld), 0);
    // stall with the slave not ready
    step(); arvalid = 2'b01; s_ready = 0; araddr[31:0] = 32'hABCD0000;
    @(negedge clk); chk("b_grant", 64'(arready), 2'b01);
    step(); araddr[31:0] = 32'h11110000;
    @(negedge clk); chk("b_send", 64'(s_valid), 1); chk("b_addr", 64'(s_addr), 32'hABCD0000);
    repeat (4) begin
      step();
      @(negedge clk);
      chk("b_hold_v", 64'(s_valid), 1); chk("b_hold_r", 64'(arready), 0); chk("b_hold_a", 64'(s_addr), 32'hABCD0000);
    end
    step(); s_ready = 1; arvalid = 2'b00;
    @(negedge clk); chk("b_last", 64'(s_valid), 1);
    step();
    @(negedge clk); chk("b_done", 64'(s_valid), 0); chk("b_norder", 64'(arready), 0);
    step(); rstn = 0;
    // outstanding-full masking
    step(); rstn = 1; arvalid = 2'b11; afull = 2'b01;
    @(negedge clk); chk("c_skip", 64'(arready), 2'b10);
    step(); afull = 2'b00;
    @(negedge clk); chk("c_send", 64'(s_valid), 1);
    step();
    @(negedge clk); chk("c_wrap", 64'(arready), 2'b01);
    step(); arvalid = 2'b00; rstn = 0;
    // fill the order FIFO
    step(); rstn = 1; arvalid = 2'b01;
    repeat (16) step();
    @(negedge clk); chk("d_full", 64'(ord_full), 1); chk("d_blk", 64'(arready), 0);
    step(); rlast(1);
    @(negedge clk); chk("d_popblk", 64'(arready), 0); chk("d_full2", 64'(ord_full), 1);
    step(); rlast(0);
    @(negedge clk); chk("d_nfull", 64'(ord_full), 0); chk("d_grant", 64'(arready), 2'b01);
    step(); arvalid = 2'b00;
    @(negedge clk); chk("d_refull", 64'(ord_full), 1); chk("d_send", 64'(s_valid), 1);
    // pop while empty, then reset during SEND
    step(); rstn = 0;
    step(); rstn = 1; rlast(1);
    @(negedge clk); chk("e_empty", 64'(rd_vld), 0);
    step(); rlast(0);
    @(negedge clk); chk("e_empty2", 64'(rd_vld), 0); chk("e_nfull", 64'(ord_full), 0); chk("e_idle", 64'(s_valid), 0);
    step(); arvalid = 2'b10; s_ready = 0;
    @(negedge clk); chk("f_grant1", 64'(arready), 2'b10);
    step(); arvalid = 2'b11;
    @(negedge clk); chk("f_send", 64'(s_valid), 1);
    step(); rstn = 0;
    step();
    @(negedge clk); chk("f_drop", 64'(s_valid), 0); chk("f_empty", 64'(rd_vld), 0); chk("f_rdy", 64'(arready), 0);
    step(); rstn = 1;
    @(negedge clk); chk("f_m0", 64'(arready), 2'b01);
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      step();
      rl_pct = ((c / 500) % 2) ? 8 : 60;
      rstn = $urandom_range(0, 399) != 0;
      arvalid = M'($urandom);
      afull = ($urandom_range(0, 3) == 0) ? M'($urandom) : '0;
      arid = (IW*M)'($urandom);
      araddr = {$urandom, $urandom};
      arburst = (BW*M)'($urandom);
      arlen = (LW*M)'($urandom);
      arsize = (SW*M)'($urandom);
      s_ready = $urandom_range(0, 2) != 0;
      rv = $urandom_range(0, 99) < rl_pct + 20;
      rr = $urandom_range(0, 3) != 0;
      rl = $urandom_range(0, 99) < rl_pct + 20;
    end
    step(); rstn = 1;
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
